fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- PC-generation and fetch stage that sits directly upstream of the combinational instruction ROM (256 words, byte address bits [9:2]).
- Drives instr_addr, samples the returned instruction word in the same cycle, and registers {pc, instr, pc+4} into an output slot.
- The output slot is consumed by decode through a valid/ready handshake.
- Handles branch/jump redirects, backpressure stalls, and fetch faults (misaligned or out-of-window PC).

Parameters:
- RESET_PC, 32'h00000000, PC loaded on reset.
- IMEM_BYTES, 1024, size of the fetchable window in bytes. A PC >= IMEM_BYTES is out of range. Must be a multiple of 4.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- instr_addr  output  32  byte address to instruction memory; equals the PC register (combinational from the register).
- instr  input  32  instruction word returned combinationally for instr_addr.
- out_valid  output  1  output slot holds a valid instruction.
- out_ready  input  1  consumer accepts the slot this cycle.
- out_instr  output  32  registered instruction.
- out_pc  output  32  address of out_instr.
- out_pc_plus4  output  32  out_pc + 4 (mod 2^32).
- redirect_valid  input  1  branch/jump taken; load redirect_pc.
- redirect_pc  input  32  redirect target.
- fault  output  1  sticky fetch fault; unit is halted.
- fault_pc  output  32  PC that caused the fault.

Behaviour:
- State machine: states RUN and HALT.
- Reset (rst=1 at an edge):
  - pc=RESET_PC, state=RUN.
  - out_valid=0; out_instr=32'h00000013 (NOP); out_pc=0; out_pc_plus4=0.
  - fault=0; fault_pc=0.
  - Reset overrides every other input. Reset mid-stall or mid-redirect discards the slot.
- Slot free: slot_free = !out_valid || out_ready.
- Edge evaluation priority in RUN (highest first):
  1. redirect_valid=1:
     - out_valid<=0 (in-flight slot flushed, even if out_ready=1 this cycle; the handshake still counts as accepted).
     - If redirect_pc[1:0]!=0 or redirect_pc>=IMEM_BYTES: state<=HALT, fault<=1, fault_pc<=redirect_pc, pc unchanged.
     - Otherwise pc<=redirect_pc.
  2. slot_free and pc>=IMEM_BYTES: state<=HALT, fault<=1, fault_pc<=pc, out_valid<=0.
  3. slot_free:
     - out_instr<=instr, out_pc<=pc, out_pc_plus4<=pc+4, out_valid<=1.
     - pc<=pc+4 (32-bit wrap; never reachable in practice because the window check fires first).
  4. Otherwise (out_valid=1, out_ready=0): hold pc and all out_* stable.
- HALT:
  - pc and out_* frozen; out_valid=0.
  - redirect_valid is ignored; only rst exits HALT.
- Latency:
  - First valid slot appears one edge after the reset edge is released.
  - With out_ready held at 1, throughput is one instruction per cycle.
  - After an accepted redirect, the first target instruction appears on the second edge: one bubble cycle with out_valid=0.
- pc[1:0] is always 0 in RUN by construction.
- instr_addr[31:10] is passed unmodified; the window check uses the full 32-bit pc.
- Redirect while out_valid=1 and out_ready=0: the redirect wins and the stalled slot is dropped.

Test Plan:
- Reset, RESET_PC=0, ROM[0..3]=A,B,C,D, out_ready=1 -> out_valid rises 1 cycle after reset release. out_pc sequence 0,4,8,12 with out_instr A,B,C,D; out_pc_plus4 = 4,8,12,16.
- Stall: out_ready=0 for 3 cycles while out_pc=4 -> out_pc=4 and out_instr=B held stable, instr_addr held at 8. After out_ready returns to 1, the next slot is out_pc=8 (no skip, no duplicate).
- Redirect: redirect_pc=0x40 asserted while out_pc=8 is stalled -> next cycle out_valid=0; the following cycle out_pc=0x40 with out_instr=ROM[16].
- Misaligned redirect: redirect_pc=0x42 -> fault=1, fault_pc=0x42, out_valid=0. A later redirect to 0x0 is ignored. Asserting rst clears the fault and restarts at RESET_PC.
- Window end: RESET_PC=0x3F8, out_ready=1 -> slots 0x3F8 and 0x3FC are produced. The next edge sets fault=1 with fault_pc=0x400.
- Reset mid-stream: assert rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0, instr_addr=RESET_PC, fault=0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation and fetch stage in front of a combinational
// instruction ROM. It registers {pc, instr, pc+4} into one output slot that
// decode drains through a valid/ready handshake. Redirects flush the slot.
// A misaligned or out-of-window PC halts the unit with a sticky fault, and
// only rst clears it.
//
// Handshake: a slot transfers on any rising edge where out_valid && out_ready.
// While out_valid=1 and out_ready=0, out_instr/out_pc/out_pc_plus4 hold
// stable. The producer never withdraws out_valid, except on a redirect,
// a fault or rst.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] instr_addr,
  input  logic [31:0] instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic        state_dbg
);

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);
  localparam logic [31:0] NOP        = 32'h0000_0013;

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_out_valid;
  logic [31:0] r_out_instr;
  logic [31:0] r_out_pc;
  logic [31:0] r_out_pc_plus4;
  logic        r_fault;
  logic [31:0] r_fault_pc;

  state_t      w_state_nx;
  logic [31:0] w_pc_nx;
  logic        w_valid_nx;
  logic [31:0] w_instr_nx;
  logic [31:0] w_out_pc_nx;
  logic [31:0] w_plus4_nx;
  logic        w_fault_nx;
  logic [31:0] w_fault_pc_nx;

  logic        w_slot_free;
  logic        w_redir_bad;
  logic [31:0] w_pc_plus4;

  assign w_slot_free = !r_out_valid || out_ready;
  assign w_redir_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc >= IMEM_LIMIT);
  assign w_pc_plus4  = r_pc + 32'd4;

  // Next-state and next-slot selection: redirect, then window fault, then capture, else hold.
  always_comb begin
    w_state_nx    = r_state;
    w_pc_nx       = r_pc;
    w_valid_nx    = r_out_valid;
    w_instr_nx    = r_out_instr;
    w_out_pc_nx   = r_out_pc;
    w_plus4_nx    = r_out_pc_plus4;
    w_fault_nx    = r_fault;
    w_fault_pc_nx = r_fault_pc;
    case (r_state)
      S_RUN: begin
        if (redirect_valid) begin
          // The in-flight slot is flushed even if it is also being accepted.
          w_valid_nx = 1'b0;
          if (w_redir_bad) begin
            w_state_nx    = S_HALT;
            w_fault_nx    = 1'b1;
            w_fault_pc_nx = redirect_pc;
          end else begin
            w_pc_nx = redirect_pc;
          end
        end else if (w_slot_free && (r_pc >= IMEM_LIMIT)) begin
          w_state_nx    = S_HALT;
          w_fault_nx    = 1'b1;
          w_fault_pc_nx = r_pc;
          w_valid_nx    = 1'b0;
        end else if (w_slot_free) begin
          w_instr_nx  = instr;
          w_out_pc_nx = r_pc;
          w_plus4_nx  = w_pc_plus4;
          w_valid_nx  = 1'b1;
          w_pc_nx     = w_pc_plus4;
        end
      end
      S_HALT: begin
        w_valid_nx = 1'b0;
      end
      default: begin
        w_state_nx = S_HALT;
        w_valid_nx = 1'b0;
      end
    endcase
  end

  // State and slot registers; rst overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_RUN;
      r_pc           <= RESET_PC;
      r_out_valid    <= 1'b0;
      r_out_instr    <= NOP;
      r_out_pc       <= 32'h0;
      r_out_pc_plus4 <= 32'h0;
      r_fault        <= 1'b0;
      r_fault_pc     <= 32'h0;
    end else begin
      r_state        <= w_state_nx;
      r_pc           <= w_pc_nx;
      r_out_valid    <= w_valid_nx;
      r_out_instr    <= w_instr_nx;
      r_out_pc       <= w_out_pc_nx;
      r_out_pc_plus4 <= w_plus4_nx;
      r_fault        <= w_fault_nx;
      r_fault_pc     <= w_fault_pc_nx;
    end
  end

  assign instr_addr   = r_pc;
  assign out_valid    = r_out_valid;
  assign out_instr    = r_out_instr;
  assign out_pc       = r_out_pc;
  assign out_pc_plus4 = r_out_pc_plus4;
  assign fault        = r_fault;
  assign fault_pc     = r_fault_pc;
  assign state_dbg    = (r_state == S_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed test-plan scenarios plus randomized traffic that is
// checked against a behavioural model of the fetch stage. A second instance
// starts near the top of the window and exercises the end-of-window fault.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] instr_addr;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fault;
  logic [31:0] fault_pc;
  logic        state_dbg;

  logic        w_rst;
  logic [31:0] w_instr_addr;
  logic [31:0] w_instr;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [31:0] w_out_instr;
  logic [31:0] w_out_pc;
  logic [31:0] w_out_pc_plus4;
  logic        w_fault;
  logic [31:0] w_fault_pc;
  logic        w_state_dbg;

  logic [31:0] rom [256];
  logic [31:0] exp_q [$];

  int checks = 0;
  int errors = 0;

  // Behavioural model of the main instance.
  logic [31:0] m_pc;
  logic        m_halt;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_out_pc;
  logic [31:0] m_plus4;
  logic        m_fault;
  logic [31:0] m_fault_pc;

  fetch_unit #(.RESET_PC(32'h0), .IMEM_BYTES(1024)) dut (
    .clk(clk), .rst(rst), .instr_addr(instr_addr), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fault(fault), .fault_pc(fault_pc), .state_dbg(state_dbg)
  );

  fetch_unit #(.RESET_PC(32'h0000_03F8), .IMEM_BYTES(1024)) dut_w (
    .clk(clk), .rst(w_rst), .instr_addr(w_instr_addr), .instr(w_instr),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_instr(w_out_instr),
    .out_pc(w_out_pc), .out_pc_plus4(w_out_pc_plus4),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .fault(w_fault), .fault_pc(w_fault_pc), .state_dbg(w_state_dbg)
  );

  assign instr   = rom[instr_addr[9:2]];
  assign w_instr = rom[w_instr_addr[9:2]];

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply the fetch rules to the model for one edge, then advance the clock.
  task automatic tick();
    logic free;
    free = !m_valid || out_ready;
    if (rst) begin
      m_pc = 32'h0; m_halt = 1'b0; m_valid = 1'b0; m_instr = 32'h13;
      m_out_pc = 32'h0; m_plus4 = 32'h0; m_fault = 1'b0; m_fault_pc = 32'h0;
    end else if (!m_halt) begin
      if (redirect_valid) begin
        m_valid = 1'b0;
        if ((redirect_pc % 4 != 0) || (redirect_pc >= 32'd1024)) begin
          m_halt = 1'b1; m_fault = 1'b1; m_fault_pc = redirect_pc;
        end else begin
          m_pc = redirect_pc;
        end
      end else if (free && m_pc >= 32'd1024) begin
        m_halt = 1'b1; m_fault = 1'b1; m_fault_pc = m_pc; m_valid = 1'b0;
      end else if (free) begin
        m_instr = rom[m_pc[9:2]]; m_out_pc = m_pc; m_plus4 = m_pc + 32'd4;
        m_valid = 1'b1; m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (out_instr !== 32'h13) begin errors++; $display("FAIL reset_instr got %h exp 00000013", out_instr); end
    checks++; if (out_pc !== 32'h0 || out_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pc got %h/%h exp 0/0", out_pc, out_pc_plus4); end
    checks++; if (fault !== 1'b0 || fault_pc !== 32'h0) begin errors++; $display("FAIL reset_fault got %b/%h exp 0/0", fault, fault_pc); end
    checks++; if (instr_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", instr_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] e;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++; if (out_valid !== 1'b1 || out_pc !== e) begin errors++; $display("FAIL stream_pc[%0d] got v=%b %h exp v=1 %h", i, out_valid, out_pc, e); end
      checks++; if (out_instr !== rom[i]) begin errors++; $display("FAIL stream_instr[%0d] got %h exp %h", i, out_instr, rom[i]); end
      checks++; if (out_pc_plus4 !== e + 32'd4) begin errors++; $display("FAIL stream_plus4[%0d] got %h exp %h", i, out_pc_plus4, e + 32'd4); end
    end
  endtask

  task automatic test_stall_redirect();
    rst = 1'b1; tick(); rst = 1'b0; out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_instr !== rom[1]) begin errors++; $display("FAIL stall_hold[%0d] got v=%b %h %h exp v=1 4 %h", i, out_valid, out_pc, out_instr, rom[1]); end
      checks++; if (instr_addr !== 32'h8) begin errors++; $display("FAIL stall_addr[%0d] got %h exp 8", i, instr_addr); end
    end
    out_ready = 1'b1; tick();
    checks++; if (out_pc !== 32'h8 || out_instr !== rom[2]) begin errors++; $display("FAIL stall_resume got %h %h exp 8 %h", out_pc, out_instr, rom[2]); end
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40; tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redirect_bubble got %b exp 0", out_valid); end
    redirect_valid = 1'b0; out_ready = 1'b1; tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== rom[16]) begin errors++; $display("FAIL redirect_target got v=%b %h %h exp v=1 40 %h", out_valid, out_pc, out_instr, rom[16]); end
  endtask

  task automatic test_misaligned();
    logic [31:0] addr_hold;
    redirect_valid = 1'b1; redirect_pc = 32'h42; tick();
    checks++; if (fault !== 1'b1 || fault_pc !== 32'h42 || out_valid !== 1'b0) begin errors++; $display("FAIL misalign_fault got f=%b %h v=%b exp f=1 42 v=0", fault, fault_pc, out_valid); end
    addr_hold = instr_addr;
    redirect_pc = 32'h0; tick(); tick();
    redirect_valid = 1'b0;
    checks++; if (fault !== 1'b1 || instr_addr !== addr_hold || out_valid !== 1'b0 || instr_addr !== m_pc) begin errors++; $display("FAIL halt_ignores_redirect got f=%b addr=%h exp f=1 addr=%h", fault, instr_addr, m_pc); end
    rst = 1'b1; tick();
    checks++; if (fault !== 1'b0 || instr_addr !== 32'h0 || state_dbg !== 1'b0) begin errors++; $display("FAIL fault_clear got f=%b addr=%h st=%b exp 0 0 0", fault, instr_addr, state_dbg); end
    rst = 1'b0; tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL restart got v=%b %h exp v=1 0", out_valid, out_pc); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1; tick(); tick();
    out_ready = 1'b0; tick();
    rst = 1'b1; tick();
    checks++; if (out_valid !== 1'b0 || instr_addr !== 32'h0 || fault !== 1'b0) begin errors++; $display("FAIL reset_mid got v=%b addr=%h f=%b exp 0 0 0", out_valid, instr_addr, fault); end
    rst = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 600; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 79) == 0);
      r = $urandom_range(0, 19);
      redirect_valid = (r < 2);
      if (r == 0) redirect_pc = $urandom();
      else redirect_pc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      tick();
      checks++; if (instr_addr !== m_pc || state_dbg !== m_halt) begin errors++; $display("FAIL rand_pc[%0d] got %h st=%b exp %h st=%b", i, instr_addr, state_dbg, m_pc, m_halt); end
      checks++; if (out_valid !== m_valid || out_pc !== m_out_pc || out_instr !== m_instr || out_pc_plus4 !== m_plus4) begin errors++; $display("FAIL rand_slot[%0d] got v=%b %h %h %h exp v=%b %h %h %h", i, out_valid, out_pc, out_instr, out_pc_plus4, m_valid, m_out_pc, m_instr, m_plus4); end
      checks++; if (fault !== m_fault || fault_pc !== m_fault_pc) begin errors++; $display("FAIL rand_fault[%0d] got %b %h exp %b %h", i, fault, fault_pc, m_fault, m_fault_pc); end
    end
    redirect_valid = 1'b0; rst = 1'b0;
  endtask

  task automatic test_window_end();
    w_out_ready = 1'b1; w_rst = 1'b1; tick(); w_rst = 1'b0;
    tick();
    checks++; if (w_out_valid !== 1'b1 || w_out_pc !== 32'h3F8 || w_out_instr !== rom[254]) begin errors++; $display("FAIL win_slot0 got v=%b %h %h exp v=1 3f8 %h", w_out_valid, w_out_pc, w_out_instr, rom[254]); end
    tick();
    checks++; if (w_out_valid !== 1'b1 || w_out_pc !== 32'h3FC || w_out_pc_plus4 !== 32'h400) begin errors++; $display("FAIL win_slot1 got v=%b %h %h exp v=1 3fc 400", w_out_valid, w_out_pc, w_out_pc_plus4); end
    tick();
    checks++; if (w_fault !== 1'b1 || w_fault_pc !== 32'h400 || w_out_valid !== 1'b0) begin errors++; $display("FAIL win_fault got f=%b %h v=%b exp f=1 400 v=0", w_fault, w_fault_pc, w_out_valid); end
    tick();
    checks++; if (w_fault !== 1'b1 || w_out_valid !== 1'b0 || w_instr_addr !== 32'h400) begin errors++; $display("FAIL win_halt got f=%b v=%b addr=%h exp 1 0 400", w_fault, w_out_valid, w_instr_addr); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = $urandom();
    rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    w_rst = 1'b1; w_out_ready = 1'b1;
    m_pc = 32'h0; m_halt = 1'b0; m_valid = 1'b0; m_instr = 32'h13;
    m_out_pc = 32'h0; m_plus4 = 32'h0; m_fault = 1'b0; m_fault_pc = 32'h0;
    test_reset();
    test_stream();
    test_stall_redirect();
    test_misaligned();
    test_reset_midstream();
    test_random();
    test_window_end();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
